// File: rtl/cr_tlvp_ob_arb_pkg.sv
// Shared AXI4-S data-path types for the TLV-parser outbound arbiter.
// Also holds the index-width helper used by the arbiter and its picker.
package cr_tlvp_ob_arb_pkg;

  localparam int DP_DATA_W = 32;
  localparam int DP_KEEP_W = DP_DATA_W / 8;

  typedef struct packed {
    logic                 tvalid;
    logic                 tlast;
    logic [DP_KEEP_W-1:0] tkeep;
    logic [DP_DATA_W-1:0] tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cr_tlvp_ob_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping from N_REQ-1 back to 0.
module cr_rr_pick
  import cr_tlvp_ob_arb_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int GW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [GW-1:0]    i_ptr,
  output logic [GW-1:0]    o_win,
  output logic             o_any
);

  localparam logic [GW:0] NQ = (GW+1)'(N_REQ);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [GW-1:0]      w_off;
  logic [GW:0]        w_sum;
  logic [GW:0]        w_wrap;

  // Rotating a doubled copy puts the pointer position at bit 0.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N_REQ-1:0];

  always_comb begin
    w_off = '0;
    o_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!o_any && w_rot[k]) begin
        w_off = k[GW-1:0];
        o_any = 1'b1;
      end
    end
  end

  assign w_sum  = {1'b0, i_ptr} + {1'b0, w_off};
  assign w_wrap = (w_sum >= NQ) ? (w_sum - NQ) : w_sum;
  assign o_win  = w_wrap[GW-1:0];

endmodule

// File: rtl/cr_tlvp_ob_arb.sv
// Frame-granular round-robin arbiter merging N_REQ parser outbound FIFOs
// onto one AXI4-S stream through a 2-entry registered output buffer.
module cr_tlvp_ob_arb
  import cr_tlvp_ob_arb_pkg::*;
#(
  parameter  int N_REQ   = 2,
  parameter  int RR_INIT = 0,
  localparam int GW      = idx_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_en,
  input  logic [N_REQ-1:0] tlvp_ob_empty,
  input  axi4s_dp_bus_t    tlvp_ob [N_REQ],
  output logic [N_REQ-1:0] tlvp_ob_rd,
  input  axi4s_dp_rdy_t    axi4s_ob_in,
  output axi4s_dp_bus_t    axi4s_ob_out,
  output logic [GW-1:0]    cur_grant,
  output logic             busy,
  output logic             frame_done,
  output logic [GW-1:0]    frame_done_id
);

  // state   | meaning
  // ST_IDLE | no lock; arbitrate among eligible requesters
  // ST_XFER | locked to r_grant until its tlast beat is popped
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  localparam logic [GW-1:0] LAST_IDX = GW'(N_REQ - 1);

  logic [0:0]    r_state;
  logic [GW-1:0] r_rr_ptr;
  logic [GW-1:0] r_grant;
  logic          r_fd;
  logic [GW-1:0] r_fd_id;
  logic [1:0]    r_cnt;
  axi4s_dp_bus_t r_buf0;
  axi4s_dp_bus_t r_buf1;

  logic [N_REQ-1:0] w_elig;
  logic [GW-1:0]    w_win;
  logic             w_any;
  logic             w_obuf_ok;
  logic [GW-1:0]    w_sel;
  logic             w_pop;
  logic             w_last;
  logic             w_out_pop;
  logic [GW-1:0]    w_ptr_nxt;
  axi4s_dp_bus_t    w_beat;
  axi4s_dp_bus_t    w_push;

  assign w_elig = req_en & ~tlvp_ob_empty;

  cr_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req (w_elig),
    .i_ptr (r_rr_ptr),
    .o_win (w_win),
    .o_any (w_any)
  );

  assign w_obuf_ok = (r_cnt != 2'd2);
  assign w_out_pop = (r_cnt != 2'd0) & axi4s_ob_in.tready;

  // r_fd doubles as the re-arbitration bubble after every tlast pop.
  always_comb begin
    w_sel = r_grant;
    w_pop = 1'b0;
    if (r_state == ST_IDLE) begin
      w_sel = w_win;
      w_pop = w_any & w_obuf_ok & ~r_fd;
    end else begin
      w_pop = ~tlvp_ob_empty[r_grant] & w_obuf_ok;
    end
  end

  assign w_beat    = tlvp_ob[w_sel];
  assign w_last    = w_beat.tlast;
  assign w_ptr_nxt = (w_sel == LAST_IDX) ? '0 : (w_sel + 1'b1);

  always_comb begin
    w_push        = w_beat;
    w_push.tvalid = 1'b1;
  end

  always_comb begin
    tlvp_ob_rd = '0;
    if (w_pop) tlvp_ob_rd[w_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= GW'(RR_INIT);
      r_grant  <= GW'(RR_INIT);
      r_fd     <= 1'b0;
      r_fd_id  <= '0;
    end else begin
      r_fd <= w_pop & w_last;
      if (w_pop) begin
        r_grant <= w_sel;
        if (w_last) begin
          r_state  <= ST_IDLE;
          r_rr_ptr <= w_ptr_nxt;
          r_fd_id  <= w_sel;
        end else begin
          r_state <= ST_XFER;
        end
      end
    end
  end

  // A push never meets a full buffer and a pop never meets an empty one,
  // so push+pop only occurs with exactly one entry held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 2'd0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      case ({w_pop, w_out_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_buf0 <= w_push;
          else               r_buf1 <= w_push;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: r_buf0 <= w_push;
        default: ;
      endcase
    end
  end

  assign axi4s_ob_out  = (r_cnt != 2'd0) ? r_buf0 : '0;
  assign busy          = (r_state == ST_XFER) | (r_cnt != 2'd0);
  assign cur_grant     = r_grant;
  assign frame_done    = r_fd;
  assign frame_done_id = r_fd_id;

  a_rd_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(tlvp_ob_rd));
  a_rd_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
    ((tlvp_ob_rd & tlvp_ob_empty) == '0));

endmodule
